// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 64-bit machine timer with prescaler and level irq.
// Define TIMER_SNAPSHOT_EN to make a MTIME_LO read latch mtime[63:32] for the following MTIME_HI read.
module mmio_timer #(
   parameter int PRESCALE_W = 8,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [3:0]        wenable,
   output logic [31:0]       rdata,
   output logic              irq
);
   logic [63:0] mtime, mtimecmp;
   logic en;
   logic [PRESCALE_W-1:0] div, pcnt;
   logic [31:0] bmask, ctrl, ctrl_new, rval, mt_lo, mt_hi, hi_rd;
   logic [2:0] idx;
   logic wr, rd, tick, div_wr, mt_wr, unused_bits;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [31:0] m);
      return (old & ~m) | (d & m);
   endfunction

   assign idx = addr[4:2];
   assign wr = sel && |wenable;
   assign rd = sel && wenable == 4'h0;
   assign bmask = {{8{wenable[3]}}, {8{wenable[2]}}, {8{wenable[1]}}, {8{wenable[0]}}};
   assign ctrl = 32'({div, 8'(en)});
   assign ctrl_new = merge(ctrl, wdata, bmask);
   assign div_wr = wr && idx == 3'd4 && |bmask[8 +: PRESCALE_W];
   assign tick = en && pcnt == div;
   // a write to either mtime half replaces the increment, carry included
   assign mt_wr = wr && (idx == 3'd0 || idx == 3'd1);
   assign mt_lo = (wr && idx == 3'd0) ? merge(mtime[31:0], wdata, bmask) : mtime[31:0];
   assign mt_hi = (wr && idx == 3'd1) ? merge(mtime[63:32], wdata, bmask) : mtime[63:32];
   assign unused_bits = ^{addr, ctrl_new};

`ifdef TIMER_SNAPSHOT_EN
   logic [31:0] shadow;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) shadow <= '0;
      else if (rd && idx == 3'd0) shadow <= mtime[63:32];
   end
   assign hi_rd = shadow;
`else
   assign hi_rd = mtime[63:32];
`endif

   always_comb begin
      rval = 32'h0;
      case (idx)
         3'd0: rval = mtime[31:0];
         3'd1: rval = hi_rd;
         3'd2: rval = mtimecmp[31:0];
         3'd3: rval = mtimecmp[63:32];
         3'd4: rval = ctrl;
         3'd5: rval = {31'h0, irq};
         default: rval = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime <= '0;
         mtimecmp <= '1;
         en <= 1'b0;
         div <= '0;
         pcnt <= '0;
         rdata <= '0;
         irq <= 1'b0;
      end else begin
         rdata <= rd ? rval : 32'h0;
         irq <= mtime >= mtimecmp;
         pcnt <= (div_wr || tick) ? '0 : en ? pcnt + PRESCALE_W'(1) : pcnt;
         mtime <= mt_wr ? {mt_hi, mt_lo} : tick ? mtime + 64'd1 : mtime;
         if (wr && idx == 3'd2) mtimecmp[31:0] <= merge(mtimecmp[31:0], wdata, bmask);
         if (wr && idx == 3'd3) mtimecmp[63:32] <= merge(mtimecmp[63:32], wdata, bmask);
         if (wr && idx == 3'd4) begin
            en <= ctrl_new[0];
            div <= ctrl_new[8 +: PRESCALE_W];
         end
      end
   end
endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: randomized bench for mmio_timer against a behavioural register-level model.
module tb_mmio_timer;
   logic clk = 1'b0, rst_n = 1'b0, sel = 1'b0;
   logic [4:0] addr = 5'h0;
   logic [31:0] wdata = 32'h0, rdata;
   logic [3:0] wenable = 4'h0;
   logic irq;
   int checks = 0, errors = 0;
   longint unsigned m_mt, m_cmp;
   bit m_en, exp_irq;
   int unsigned m_div, m_pc;
   logic [31:0] m_sh, exp_rdata, v, v2;

   mmio_timer dut (.clk(clk), .rst_n(rst_n), .sel(sel), .addr(addr), .wdata(wdata),
                   .wenable(wenable), .rdata(rdata), .irq(irq));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      lanes = old;
      for (int b = 0; b < 4; b++) if (be[b]) lanes[8*b +: 8] = d[8*b +: 8];
   endfunction

   function automatic logic [31:0] ctrl_val();
      return {16'h0, 8'(m_div), 7'h0, m_en};
   endfunction

   function automatic logic [31:0] reg_val(input int i);
      case (i)
         0: return m_mt[31:0];
`ifdef TIMER_SNAPSHOT_EN
         1: return m_sh;
`else
         1: return m_mt[63:32];
`endif
         2: return m_cmp[31:0];
         3: return m_cmp[63:32];
         4: return ctrl_val();
         5: return {31'h0, exp_irq};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_reset();
      m_mt = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 0; m_div = 0; m_pc = 0;
      m_sh = 0; exp_rdata = 0; exp_irq = 0;
   endtask

   task automatic model_edge(input bit s, input logic [4:0] a, input logic [31:0] d, input logic [3:0] we);
      int i;
      bit wr, rd, tick;
      int unsigned next_pc;
      logic [31:0] lo, hi, ctl;
      i = int'(a[4:2]);
      wr = s && we != 0;
      rd = s && we == 0;
      lo = m_mt[31:0];
      hi = m_mt[63:32];
      exp_rdata = rd ? reg_val(i) : 32'h0;
      if (rd && i == 0) m_sh = hi;
      exp_irq = m_mt >= m_cmp;
      tick = m_en && m_pc == m_div;
      next_pc = !m_en ? m_pc : tick ? 0 : m_pc + 1;
      if (wr && i == 0) m_mt = {hi, lanes(lo, d, we)};
      else if (wr && i == 1) m_mt = {lanes(hi, d, we), lo};
      else if (tick) m_mt = m_mt + 1;
      if (wr && i == 2) m_cmp[31:0] = lanes(m_cmp[31:0], d, we);
      if (wr && i == 3) m_cmp[63:32] = lanes(m_cmp[63:32], d, we);
      if (wr && i == 4) begin
         ctl = lanes(ctrl_val(), d, we);
         m_en = ctl[0];
         m_div = int'(ctl[15:8]);
         if (we[1]) next_pc = 0;
      end
      m_pc = next_pc;
   endtask

   task automatic step(input bit s, input logic [4:0] a, input logic [31:0] d, input logic [3:0] we);
      sel = s; addr = a; wdata = d; wenable = we;
      @(posedge clk);
      model_edge(s, a, d, we);
      #2;
      chk("rdata", 64'(rdata), 64'(exp_rdata));
      chk("irq", 64'(irq), 64'(exp_irq));
      sel = 1'b0; wenable = 4'h0;
   endtask

   task automatic wr(input int i, input logic [31:0] d, input logic [3:0] we);
      step(1'b1, 5'(i * 4), d, we);
   endtask

   task automatic rd(input int i, output logic [31:0] r);
      step(1'b1, 5'(i * 4), 32'h0, 4'h0);
      r = rdata;
   endtask

   initial begin
      int n, a;
      logic [3:0] we;
      logic [31:0] d;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("reset_rdata", 64'(rdata), 64'h0);
      chk("reset_irq", 64'(irq), 64'h0);
      rst_n = 1'b1;
      rd(4, v); chk("reset_ctrl", 64'(v), 64'h0);
      rd(0, v); chk("reset_mtime_lo", 64'(v), 64'h0);
      rd(3, v); chk("reset_cmp_hi", 64'(v), 64'hFFFF_FFFF);
      wr(2, 32'hAABB_CCDD, 4'b0101);
      rd(2, v); chk("byte_strobe", 64'(v), 64'hFFBB_FFDD);
      wr(4, 32'h0000_0301, 4'hF);
      repeat (40) step(1'b0, 5'h0, 32'h0, 4'h0);
      rd(0, v);
      checks++;
      if (v < 9 || v > 11) begin
         errors++;
         $display("FAIL prescale: got %0d expected 10 +-1", v);
      end
      wr(4, 32'h1, 4'hF);
      rd(0, v); rd(0, v2); chk("div0_step", 64'(v2), 64'(v + 1));
      wr(0, 32'hFFFF_FFFE, 4'hF);
      wr(1, 32'h0, 4'hF);
      step(1'b0, 5'h0, 32'h0, 4'h0);
      step(1'b0, 5'h0, 32'h0, 4'h0);
      rd(1, v); chk("carry_hi", 64'(v), 64'h1);
      wr(0, 32'h1234, 4'hF);
      rd(0, v); chk("write_wins", 64'(v), 64'h1234);
      wr(4, 32'h0, 4'hF);
      wr(0, 32'h0, 4'hF); wr(1, 32'h0, 4'hF);
      wr(3, 32'h0, 4'hF); wr(2, 32'd20, 4'hF);
      wr(4, 32'h1, 4'hF);
      n = 0;
      while (!irq && n < 100) begin
         step(1'b0, 5'h0, 32'h0, 4'h0);
         n++;
      end
      chk("irq_rise_cycle", 64'(n), 64'd21);
      wr(3, 32'h1, 4'hF);
      chk("irq_hold", 64'(irq), 64'h1);
      step(1'b0, 5'h0, 32'h0, 4'h0);
      chk("irq_fall", 64'(irq), 64'h0);
      rd(5, v); chk("status", 64'(v), 64'h0);
      wr(4, 32'h0, 4'hF);
      wr(0, 32'hFFFF_FFFF, 4'hF); wr(1, 32'h0, 4'hF);
      wr(4, 32'h1, 4'hF);
      rd(0, v); chk("snap_lo", 64'(v), 64'hFFFF_FFFF);
      rd(1, v);
`ifdef TIMER_SNAPSHOT_EN
      chk("snap_hi", 64'(v), 64'h0);
`else
      chk("snap_hi", 64'(v), 64'h1);
`endif
      sel = 1'b1; addr = 5'h10; wdata = 32'h0000_0101; wenable = 4'hF;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midreset_rdata", 64'(rdata), 64'h0);
      chk("midreset_irq", 64'(irq), 64'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      sel = 1'b0; wenable = 4'h0;
      rd(4, v); chk("midreset_ctrl", 64'(v), 64'h0);
      for (int k = 0; k < 3000; k++) begin
         a = $urandom_range(0, 7);
         we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
         d = $urandom;
         if (a == 4) d = {16'h0, 8'($urandom_range(0, 3)), 7'h0, 1'($urandom_range(0, 3) != 0)};
         if (a == 1 || a == 3) d = $urandom_range(0, 2);
         step($urandom_range(0, 4) != 0, 5'(a * 4 + $urandom_range(0, 3)), d, we);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
